ysyx_2022040010_dcache_miss_ctrl: RTL and testbench
===================================================

// Module: ysyx_2022040010_dcache_miss_ctrl
// PURPOSE
//  Dcache miss handler, downstream of the dcache tag array. Consumes miss/dirty/dirty_addr/lru.
//  Per miss: optional 2-beat AXI write-back of the dirty victim line, then 2-beat AXI refill.
//  Ends with a one-cycle refresh pulse to the tag array and a line write to the data array.
//  Holds stallreq to the pipeline until refresh.
// PARAMETERS
//  ADDR_W      64   physical address width
//  BEAT_W      64   AXI data width; line = 2*BEAT_W = 128 bits (16-byte line, 4-bit offset)
//  INDEX_W     6    set-index width (64 sets)
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous, active-high reset
//  flush        in   1        pipeline flush; blocks acceptance of a new miss in IDLE only
//  miss_i       in   1        tag-array miss (cacheable, enabled, no hit)
//  dirty_i      in   1        victim line dirty
//  dirty_addr_i in   ADDR_W   line-aligned victim address
//  lru_i        in   1        victim way (0 = way0, 1 = way1)
//  req_addr_i   in   ADDR_W   missing access address
//  victim_i     in   128      victim line from data array, valid in the miss_i cycle
//  stallreq     out  1        pipeline stall
//  refresh      out  1        1-cycle pulse: tag array installs the new tag
//  line_we      out  1        1-cycle pulse, same cycle as refresh
//  line_way     out  1        way written
//  line_index   out  INDEX_W  set written
//  line_data    out  128      refilled line, {beat1, beat0}
//  arvalid/arready/araddr[ADDR_W]/arlen[8]         AXI read address, arlen = 1
//  rvalid/rready/rdata[BEAT_W]/rlast/rresp[2]      AXI read data
//  awvalid/awready/awaddr[ADDR_W]/awlen[8]         AXI write address, awlen = 1
//  wvalid/wready/wdata[BEAT_W]/wlast/wstrb[8]      AXI write data, wstrb = 8'hFF
//  bvalid/bready/bresp[2]                          AXI write response
// BEHAVIOUR
//  Reset: state IDLE; all valid/ready, refresh, line_we and stallreq = 0; buffers and beat counter = 0.
//  States: IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, FILL.
//  IDLE: stallreq = miss_i & ~flush (combinational).
//   - On miss_i & ~flush: latch req_addr (offset cleared), lru_i, dirty_addr_i, victim_i.
//   - Next state: WB_AW if dirty_i, else RD_AR. flush & miss_i leaves the FSM in IDLE.
//  WB_AW: awvalid = 1, awaddr = latched dirty_addr; awready -> WB_W.
//  WB_W: wvalid = 1; wdata = victim[63:0] on beat 0, victim[127:64] on beat 1; wlast on beat 1.
//   - Beat advances on wvalid&wready. Last handshake -> WB_B.
//  WB_B: bready = 1; bvalid -> RD_AR. bresp is ignored.
//  RD_AR: arvalid = 1, araddr = latched req line address; arready -> RD_R.
//  RD_R: rready = 1; beat n stored on rvalid. rlast or second beat -> FILL.
//   - Extra beats beyond 2 are never expected; the counter saturates at 1.
//  FILL (1 cycle): refresh = line_we = 1; line_way = latched lru; line_index = req_addr[9:4] -> IDLE.
//  stallreq = 1 in every non-IDLE state. It drops the cycle after FILL; the pipeline replays and hits.
//  Valid signals, once raised, stay high with stable payload until the handshake (AXI rule).
//  flush outside IDLE is ignored: an issued AXI burst always completes and the line installs.
//  rst mid-burst returns to IDLE immediately; the external interconnect is reset alongside.
//  Latency, clean miss, zero-wait slave: IDLE->RD_AR->RD_R(2)->FILL = refresh 4 cycles after miss.
//  Dirty miss adds 4 cycles (AW, W x2, B).
// CONFIGURATION
//  DCACHE_PERF_CNT_EN defined: adds outputs perf_miss[63:0] and perf_wb[63:0].
//   - Counters are reset to 0 and increment on each accepted miss / each completed B handshake.
//  Undefined: no counter ports or logic; all other behaviour identical.
// STRUCTURE
//  Shared package/defines: state encoding, LINE_W = 128, AXI_LEN_LINE = 8'd1, AXI_SIZE_8B, and
//  the OFFSET_WIDTH/INDEX_WIDTH/TAG_WIDTH split shared with the tag array.
//  One natural sub-module: ysyx_2022040010_dcache_line_buf.
//   - Holds the 2-beat latched victim/refill line, beat counter and beat select.
// TESTING
//  Clean miss at 0x8000_0120, lru=0, zero-wait slave, rdata A then B:
//   - araddr = 0x8000_0120, arlen = 1.
//   - Refresh at cycle +4 with line_index = 0x12, line_way = 0, line_data = {B,A}.
//  Dirty miss, dirty_addr 0x8000_4120, victim {D1,D0}, lru=1:
//   - aw at 0x8000_4120, then wdata D0, D1 with wlast on D1.
//   - b handshake precedes arvalid; refresh at cycle +8 with line_way = 1.
//  Backpressure: arready held low 5 cycles:
//   - arvalid and araddr stable throughout; stallreq = 1 until FILL.
//  miss_i & flush in the same IDLE cycle -> no arvalid/awvalid, stallreq = 0.
//   - flush during RD_R -> burst completes and refresh still fires.
//  rst asserted in WB_W -> next cycle: IDLE, wvalid = 0, stallreq = 0.
//   - Next clean miss is served normally.
//  With DCACHE_PERF_CNT_EN: one clean + one dirty miss -> perf_miss = 2, perf_wb = 1.

Source files
------------

// File: rtl/ysyx_2022040010_dcache_miss_ctrl_pkg.sv
// Shared dcache miss-handler definitions: geometry split, AXI burst constants, FSM encoding.
package ysyx_2022040010_dcache_miss_ctrl_pkg;

    localparam int unsigned ADDR_W       = 64;
    localparam int unsigned BEAT_W       = 64;
    localparam int unsigned LINE_W       = 2 * BEAT_W;
    localparam int unsigned OFFSET_WIDTH = 4;
    localparam int unsigned INDEX_WIDTH  = 6;
    localparam int unsigned TAG_WIDTH    = ADDR_W - INDEX_WIDTH - OFFSET_WIDTH;

    localparam logic [7:0] AXI_LEN_LINE = 8'd1;
    localparam logic [2:0] AXI_SIZE_8B  = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_AW,
        S_WB_W,
        S_WB_B,
        S_RD_AR,
        S_RD_R,
        S_FILL
    } state_e;

endpackage

// File: rtl/ysyx_2022040010_dcache_line_buf.sv
// Two-beat line buffer: holds the victim for write-back, then collects refill beats.
module ysyx_2022040010_dcache_line_buf
    import ysyx_2022040010_dcache_miss_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              clr,
    input  logic              adv,
    input  logic              wr,
    input  logic [BEAT_W-1:0] wr_data,
    output logic              cnt,
    output logic [BEAT_W-1:0] beat,
    output logic [LINE_W-1:0] line
);

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
            cnt  <= 1'b0;
        end else if (load) begin
            line <= load_line;
            cnt  <= 1'b0;
        end else begin
            if (wr) begin
                if (cnt) line[LINE_W-1:BEAT_W] <= wr_data;
                else     line[BEAT_W-1:0]      <= wr_data;
            end
            // counter saturates at the second beat; clr rewinds it between bursts
            if (clr)            cnt <= 1'b0;
            else if (adv || wr) cnt <= 1'b1;
        end
    end

    assign beat = cnt ? line[LINE_W-1:BEAT_W] : line[BEAT_W-1:0];

endmodule

// File: rtl/ysyx_2022040010_dcache_miss_ctrl.sv
// Dcache miss handler: optional victim write-back, 2-beat refill, then tag refresh + line write.
// Optional DCACHE_PERF_CNT_EN adds perf_miss / perf_wb event counters.
module ysyx_2022040010_dcache_miss_ctrl
    import ysyx_2022040010_dcache_miss_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   miss_i,
    input  logic                   dirty_i,
    input  logic [ADDR_W-1:0]      dirty_addr_i,
    input  logic                   lru_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [LINE_W-1:0]      victim_i,
    output logic                   stallreq,
    output logic                   refresh,
    output logic                   line_we,
    output logic                   line_way,
    output logic [INDEX_WIDTH-1:0] line_index,
    output logic [LINE_W-1:0]      line_data,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_W-1:0]      araddr,
    output logic [7:0]             arlen,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [BEAT_W-1:0]      rdata,
    input  logic                   rlast,
    input  logic [1:0]             rresp,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [ADDR_W-1:0]      awaddr,
    output logic [7:0]             awlen,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [BEAT_W-1:0]      wdata,
    output logic                   wlast,
    output logic [7:0]             wstrb,
    input  logic                   bvalid,
    output logic                   bready,
    input  logic [1:0]             bresp
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [63:0]            perf_miss,
    output logic [63:0]            perf_wb
`endif
);

    state_e                state, state_nxt;
    logic [ADDR_W-1:0]     req_line;
    logic [ADDR_W-1:0]     wb_addr;
    logic                  way;
    logic                  accept, clr_cnt, adv_w, wr_r;
    logic                  cnt;
    logic [BEAT_W-1:0]     beat;
    logic                  unused_bits;

    assign unused_bits = ^{rresp, bresp, req_addr_i[OFFSET_WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // request context captured when a miss is accepted; offset cleared to the line base
    always_ff @(posedge clk) begin
        if (rst) begin
            req_line <= '0;
            wb_addr  <= '0;
            way      <= 1'b0;
        end else if (accept) begin
            req_line <= {req_addr_i[ADDR_W-1 -: TAG_WIDTH],
                         req_addr_i[OFFSET_WIDTH +: INDEX_WIDTH],
                         OFFSET_WIDTH'(0)};
            wb_addr  <= dirty_addr_i;
            way      <= lru_i;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        clr_cnt   = 1'b0;
        adv_w     = 1'b0;
        wr_r      = 1'b0;
        stallreq  = 1'b1;
        refresh   = 1'b0;
        line_we   = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        case (state)
            S_IDLE: begin
                stallreq = miss_i && !flush;
                if (miss_i && !flush) begin
                    accept    = 1'b1;
                    state_nxt = dirty_i ? S_WB_AW : S_RD_AR;
                end
            end
            S_WB_AW: begin
                awvalid = 1'b1;
                if (awready) state_nxt = S_WB_W;
            end
            S_WB_W: begin
                wvalid = 1'b1;
                wlast  = cnt;
                if (wready) begin
                    if (cnt) begin
                        clr_cnt   = 1'b1;
                        state_nxt = S_WB_B;
                    end else begin
                        adv_w = 1'b1;
                    end
                end
            end
            S_WB_B: begin
                bready = 1'b1;
                if (bvalid) state_nxt = S_RD_AR;
            end
            S_RD_AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = S_RD_R;
            end
            S_RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    wr_r = 1'b1;
                    if (rlast || cnt) state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                refresh   = 1'b1;
                line_we   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    ysyx_2022040010_dcache_line_buf u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_line (victim_i),
        .clr       (clr_cnt),
        .adv       (adv_w),
        .wr        (wr_r),
        .wr_data   (rdata),
        .cnt       (cnt),
        .beat      (beat),
        .line      (line_data)
    );

    assign araddr     = req_line;
    assign arlen      = AXI_LEN_LINE;
    assign awaddr     = wb_addr;
    assign awlen      = AXI_LEN_LINE;
    assign wdata      = beat;
    assign wstrb      = 8'((9'd1 << (4'd1 << AXI_SIZE_8B)) - 9'd1);
    assign line_way   = way;
    assign line_index = req_line[OFFSET_WIDTH +: INDEX_WIDTH];

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_miss <= '0;
            perf_wb   <= '0;
        end else begin
            if (accept)           perf_miss <= perf_miss + 64'd1;
            if (bvalid && bready) perf_wb   <= perf_wb + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_2022040010_dcache_miss_ctrl.sv
// Scoreboard bench for the dcache miss handler with a small reactive AXI slave.
module tb_ysyx_2022040010_dcache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst, flush, miss_i, dirty_i, lru_i;
    logic [63:0]  dirty_addr_i, req_addr_i;
    logic [127:0] victim_i;
    logic         stallreq, refresh, line_we, line_way;
    logic [5:0]   line_index;
    logic [127:0] line_data;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [63:0]  araddr, rdata, awaddr, wdata;
    logic [7:0]   arlen, awlen, wstrb;
    logic [1:0]   rresp, bresp;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [63:0]  perf_miss, perf_wb;

    int n_checks = 0;
    int n_errors = 0;
    int n_miss = 0;
    int n_wb = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    ysyx_2022040010_dcache_miss_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .miss_i(miss_i), .dirty_i(dirty_i),
        .dirty_addr_i(dirty_addr_i), .lru_i(lru_i), .req_addr_i(req_addr_i), .victim_i(victim_i),
        .stallreq(stallreq), .refresh(refresh), .line_we(line_we), .line_way(line_way),
        .line_index(line_index), .line_data(line_data),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
`ifdef DCACHE_PERF_CNT_EN
        , .perf_miss(perf_miss), .perf_wb(perf_wb)
`endif
    );

`ifndef DCACHE_PERF_CNT_EN
    assign perf_miss = '0;
    assign perf_wb   = '0;
`endif

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop(output logic [127:0] e);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1'b0, 1'b1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic idle_inputs();
        miss_i = 0; dirty_i = 0; lru_i = 0; flush = 0;
        dirty_addr_i = '0; req_addr_i = '0; victim_i = '0;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
    endtask

    task automatic run_miss(input logic [63:0] addr, input logic lru, input logic dirty,
                            input logic [63:0] daddr, input logic [127:0] victim,
                            input logic [63:0] ra, input logic [63:0] rb,
                            input int ar_wait, input bit flush_rd, input int exp_lat);
        int waits, rbeats, wbeat;
        bit b_pend, b_done, got_ref;
        logic [127:0] e;
        logic [63:0] line_addr;
        waits = 0; rbeats = 0; wbeat = 0;
        b_pend = 0; b_done = 0; got_ref = 0;
        line_addr = {addr[63:4], 4'h0};
        if (dirty) begin
            exp_q.push_back({64'h0, daddr});
            exp_q.push_back({64'h0, victim[63:0]});
            exp_q.push_back({64'h0, victim[127:64]});
        end
        exp_q.push_back({64'h0, line_addr});
        exp_q.push_back({rb, ra});

        @(negedge clk);
        miss_i = 1; dirty_i = dirty; dirty_addr_i = daddr; lru_i = lru;
        req_addr_i = addr; victim_i = victim; flush = 0;
        #1 check("stall_accept", stallreq, 1'b1);
        n_miss++;

        for (int cyc = 1; cyc <= 40 && !got_ref; cyc++) begin
            @(negedge clk);
            // scramble the request side so only latched values can satisfy the checks
            dirty_i = 0; dirty_addr_i = '0; req_addr_i = '0; victim_i = ~victim; lru_i = ~lru;
            awready = 0; wready = 0; bvalid = 0; arready = 0;
            rvalid = 0; rlast = 0; rdata = '0; flush = 0;
            check("stall_busy", stallreq, 1'b1);
            if (awvalid) begin
                awready = 1;
                pop(e);
                check("awaddr", awaddr, e);
                check("awlen", awlen, 8'd1);
            end
            if (wvalid) begin
                wready = 1;
                pop(e);
                check("wdata", wdata, e);
                check("wlast", wlast, wbeat == 1);
                check("wstrb", wstrb, 8'hFF);
                if (wbeat == 1) b_pend = 1;
                wbeat++;
            end
            if (bready) begin
                check("b_after_w", b_pend, 1'b1);
                bvalid = 1; b_done = 1; b_pend = 0;
                n_wb++;
            end
            if (arvalid) begin
                check("b_before_ar", b_done, dirty);
                check("araddr_stable", araddr, line_addr);
                check("arlen", arlen, 8'd1);
                if (waits < ar_wait) begin
                    waits++;
                end else begin
                    arready = 1;
                    pop(e);
                    check("araddr", araddr, e);
                    rbeats = 2;
                end
            end
            if (rready) begin
                if (flush_rd) flush = 1;
                if (rbeats > 0) begin
                    rvalid = 1;
                    rdata = (rbeats == 2) ? ra : rb;
                    rlast = (rbeats == 1);
                    rbeats--;
                end
            end
            if (refresh) begin
                got_ref = 1;
                pop(e);
                check("line_data", line_data, e);
                check("line_we", line_we, 1'b1);
                check("line_index", line_index, addr[9:4]);
                check("line_way", line_way, lru);
                check("latency", cyc, exp_lat);
                miss_i = 0;
            end
        end
        if (!got_ref) check("refresh_timeout", 1'b0, 1'b1);
        @(negedge clk);
        idle_inputs();
        #1 check("stall_release", stallreq, 1'b0);
        check("refresh_pulse", refresh, 1'b0);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_stall", stallreq, 1'b0);
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        check("rst_refresh", {refresh, line_we}, 2'b0);
        check("rst_line", line_data, 128'h0);

        // clean miss, zero-wait slave
        run_miss(64'h8000_0120, 1'b0, 1'b0, 64'h0, 128'h0,
                 64'hAAAA_0000_1111_2222, 64'hBBBB_3333_4444_5555, 0, 1'b0, 4);

        // dirty miss with write-back first
        run_miss(64'h8000_0238, 1'b1, 1'b1, 64'h8000_4120,
                 {64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000},
                 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 1'b0, 8);

        // arready held low 5 cycles
        run_miss(64'h8000_03F0, 1'b1, 1'b0, 64'h0, 128'h0,
                 64'h5555_AAAA_5555_AAAA, 64'h1234_1234_1234_1234, 5, 1'b0, 9);

        // miss with flush in the same IDLE cycle is not accepted
        @(negedge clk);
        miss_i = 1; flush = 1; dirty_i = 1; req_addr_i = 64'h8000_0500; dirty_addr_i = 64'h8000_9500;
        #1 check("flush_stall", stallreq, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("flush_no_axi", {arvalid, awvalid}, 2'b0);
        check("flush_idle_stall", stallreq, 1'b0);

        // flush during the refill burst is ignored
        run_miss(64'h8000_0A40, 1'b0, 1'b0, 64'h0, 128'h0,
                 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 0, 1'b1, 4);

        // reset while in WB_W
        @(negedge clk);
        miss_i = 1; dirty_i = 1; dirty_addr_i = 64'h8000_7700; req_addr_i = 64'h8000_0700;
        victim_i = {64'h1, 64'h2};
        @(negedge clk);
        idle_inputs();
        check("rstwb_awvalid", awvalid, 1'b1);
        awready = 1;
        @(negedge clk);
        awready = 0;
        check("rstwb_wvalid", wvalid, 1'b1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_miss = 0; n_wb = 0;
        #1;
        check("rstwb_wvalid_low", wvalid, 1'b0);
        check("rstwb_stall", stallreq, 1'b0);
        check("rstwb_valids", {arvalid, awvalid, bready, rready}, 4'b0);

        run_miss(64'h8000_0120, 1'b1, 1'b0, 64'h0, 128'h0,
                 64'h7777_8888_9999_AAAA, 64'hCCCC_DDDD_EEEE_FFFF, 0, 1'b0, 4);

`ifdef DCACHE_PERF_CNT_EN
        run_miss(64'h8000_0C10, 1'b0, 1'b1, 64'h8000_6C10, {64'h33, 64'h44},
                 64'h5, 64'h6, 0, 1'b0, 8);
        check("perf_miss", perf_miss, 64'(n_miss));
        check("perf_wb", perf_wb, 64'(n_wb));
`else
        check("perf_absent", {perf_miss, perf_wb}, 128'h0);
`endif
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
